// File: rtl/bytestreamer.sv
// Serial-to-parallel deserializer: MSB-first bit stream in, WIDTH-bit words out with a ready flag.
// Optional completed-word counter enabled by defining BYTESTREAMER_WCNT_EN.
module bytestreamer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_enable,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             byte_ready
`ifdef BYTESTREAMER_WCNT_EN
    ,
    output logic [CNT_W-1:0] word_count
`endif
);

    localparam int BC_W = $clog2(WIDTH);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_sr;
    logic [BC_W-1:0]  r_cnt;
    logic [WIDTH-1:0] r_parallel;
    logic             r_ready;
    logic [WIDTH-1:0] w_sr_next;
    logic             w_last;

    assign w_sr_next = {r_sr[WIDTH-2:0], serial_in};
    assign w_last    = (r_cnt == LAST_BIT);

    // Framing is purely by count since reset; there is no resync path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr       <= '0;
            r_cnt      <= '0;
            r_parallel <= '0;
            r_ready    <= 1'b0;
        end else if (shift_enable) begin
            r_sr <= w_sr_next;
            if (w_last) begin
                r_cnt      <= '0;
                r_parallel <= w_sr_next;
                r_ready    <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == '0) begin
                    r_ready <= 1'b0;
                end
            end
        end
    end

    assign parallel_out = r_parallel;
    assign byte_ready   = r_ready;

`ifdef BYTESTREAMER_WCNT_EN
    logic [CNT_W-1:0] r_word_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_count <= '0;
        end else if (shift_enable && w_last) begin
            r_word_count <= r_word_count + 1'b1;
        end
    end

    assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_bytestreamer.sv
// Scoreboard bench for bytestreamer: stimulus pushes expected words, a negedge monitor
// pops one on every rising byte_ready. Define BYTESTREAMER_WCNT_EN to also exercise word_count.
module tb_bytestreamer;

    localparam int WIDTH = 8;
`ifdef BYTESTREAMER_WCNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic             clk;
    logic             rst;
    logic             shift_enable;
    logic             serial_in;
    logic [WIDTH-1:0] parallel_out;
    logic             byte_ready;
`ifdef BYTESTREAMER_WCNT_EN
    logic [CNT_W-1:0] word_count;
`endif

    int tests_run;
    int tests_failed;
    logic [WIDTH-1:0] exp_q[$];
    logic prev_ready;

    bytestreamer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .shift_enable (shift_enable),
        .serial_in    (serial_in),
        .parallel_out (parallel_out),
        .byte_ready   (byte_ready)
`ifdef BYTESTREAMER_WCNT_EN
        ,
        .word_count   (word_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry per completed word.
    always @(negedge clk) begin
        if (rst) begin
            prev_ready <= 1'b0;
        end else begin
            if (byte_ready && !prev_ready) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_word: got 0x%0h expected none at %0t", parallel_out, $time);
                end else begin
                    check("word", 32'(parallel_out), 32'(exp_q.pop_front()));
                end
            end
            prev_ready <= byte_ready;
        end
    end

    task automatic shift_bit(input logic b);
        shift_enable = 1'b1;
        serial_in    = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        shift_enable = 1'b0;
        serial_in    = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        exp_q.push_back(w);
        for (int i = WIDTH - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] w;
        logic [23:0] stream;
        tests_run    = 0;
        tests_failed = 0;
        prev_ready   = 1'b0;
        rst          = 1'b1;
        shift_enable = 1'b0;
        serial_in    = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out", 32'(parallel_out), 32'h0);
        check("reset_ready", 32'(byte_ready), 32'h0);
        rst = 1'b0;

        // Load a nonzero word, then reset asynchronously between edges.
        send_word(8'hC3);
        idle(1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out", 32'(parallel_out), 32'h0);
        check("async_rst_ready", 32'(byte_ready), 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);

        // Partial word discarded by reset.
        for (int i = 0; i < 3; i++) shift_bit(1'b1);
        shift_enable = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_word(8'h12);
        idle(1);
        check("after_partial_rst", 32'(parallel_out), 32'h12);

        // Single word and hold.
        send_word(8'hA5);
        idle(1);
        check("single_ready", 32'(byte_ready), 32'h1);
        check("single_out", 32'(parallel_out), 32'hA5);
        idle(5);
        check("hold_ready", 32'(byte_ready), 32'h1);
        check("hold_out", 32'(parallel_out), 32'hA5);

        // Second word: ready clears on first bit, old data held.
        w = 8'h3C;
        exp_q.push_back(w);
        shift_bit(w[7]);
        check("clear_ready", 32'(byte_ready), 32'h0);
        check("clear_out_held", 32'(parallel_out), 32'hA5);
        for (int i = 6; i >= 0; i--) shift_bit(w[i]);
        idle(1);
        check("second_ready", 32'(byte_ready), 32'h1);
        check("second_out", 32'(parallel_out), 32'h3C);

        // Gapped word.
        w = 8'h5A;
        exp_q.push_back(w);
        for (int i = 7; i >= 4; i--) shift_bit(w[i]);
        for (int g = 0; g < 3; g++) begin
            idle(1);
            check("gap_ready", 32'(byte_ready), 32'h0);
        end
        for (int i = 3; i >= 1; i--) shift_bit(w[i]);
        check("gap_pre_last_ready", 32'(byte_ready), 32'h0);
        shift_bit(w[0]);
        check("gap_ready_final", 32'(byte_ready), 32'h1);
        check("gap_out", 32'(parallel_out), 32'h5A);
        idle(2);

        // Continuous stream: one-cycle ready pulse per word.
        stream = 24'h0180FF;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'hFF);
        for (int k = 0; k < 24; k++) begin
            shift_bit(stream[23-k]);
            check("stream_ready", 32'(byte_ready), (k % 8 == 7) ? 32'h1 : 32'h0);
        end
        idle(1);
        check("stream_last_out", 32'(parallel_out), 32'hFF);

`ifdef BYTESTREAMER_WCNT_EN
        rst = 1'b1;
        @(negedge clk);
        check("wcnt_reset", 32'(word_count), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        for (int n = 1; n <= 5; n++) begin
            send_word(8'(8'h11 * n));
            idle(1);
            check("wcnt", 32'(word_count), 32'(n % 4));
        end
`endif

        idle(3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
